// File: rtl/dot_matrix_scan_ctrl.sv
// dot_matrix_scan_ctrl: double-buffered 8x8 LED scan with blanking and frame-boundary swap (in: clock Reset enable wr_* swap_req; out: row col row_idx frame_start swap_ack)
module dot_matrix_scan_ctrl #(
  parameter int ROW_CYC   = 5000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic [7:0] row,
  output logic [7:0] col,
  output logic [2:0] row_idx,
  output logic       frame_start
);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic front_q, front_d, pend_q, pend_d, fresh_q, fresh_d, ack_q, ack_d, fs_q, fs_d;
  logic [7:0] row_q, row_d, col_q, col_d;
  logic [1:0][7:0][7:0] bank_q, bank_d;
  logic last, swap;
  always_comb begin
    last = state_q != IDLE && cnt_q == 16'(ROW_CYC - 1);
    swap = enable && last && idx_q == 3'd7 && (pend_q || swap_req);
    bank_d = bank_q;
    if (wr_en) bank_d[!front_q][wr_addr] = wr_data;
    front_d = front_q ^ swap;
    pend_d = (pend_q | swap_req) & ~swap;
    cnt_d = (!enable || state_q == IDLE || last) ? 16'd0 : cnt_q + 16'd1;
    idx_d = idx_q + 3'(enable && last);
    fresh_d = fresh_q & ~enable;
    fs_d = enable && ((state_q == IDLE && fresh_q) || (last && idx_q == 3'd7));
    ack_d = swap;
    state_d = !enable ? IDLE : (cnt_d >= 16'(BLANK_CYC)) ? SHOW : BLANK;
    row_d = state_d == SHOW ? 8'h80 >> idx_d : 8'h00;
    col_d = state_d == SHOW ? ~bank_d[front_d][idx_d] : 8'hFF;
  end
  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      front_q <= 1'b0;
      pend_q  <= 1'b0;
      fresh_q <= 1'b1;
      ack_q   <= 1'b0;
      fs_q    <= 1'b0;
      row_q   <= 8'h00;
      col_q   <= 8'hFF;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      front_q <= front_d;
      pend_q  <= pend_d;
      fresh_q <= fresh_d;
      ack_q   <= ack_d;
      fs_q    <= fs_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bank_q  <= bank_d;
    end
  end
  assign swap_ack    = ack_q;
  assign frame_start = fs_q;
  assign row         = row_q;
  assign col         = col_q;
  assign row_idx     = idx_q;
endmodule

// File: tb/tb_dot_matrix_scan_ctrl.sv
// tb_dot_matrix_scan_ctrl: scenario and random checks against a frame-position reference model
module tb_dot_matrix_scan_ctrl;
  localparam int R = 8, B = 2, F = 64;
  logic clk = 1'b0;
  logic rst, en, wr_en, swap_req, swap_ack, frame_start;
  logic [2:0] wr_addr, row_idx;
  logic [7:0] wr_data, row, col;
  int checks = 0, errors = 0;
  int pos;
  bit run, fresh, pend, front;
  logic [7:0] mb [2][8];
  logic [7:0] e_row, e_col;
  logic [2:0] e_idx;
  logic e_ack, e_fs;
  dot_matrix_scan_ctrl #(.ROW_CYC(R), .BLANK_CYC(B)) dut (
    .clock(clk), .Reset(rst), .enable(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .row(row), .col(col), .row_idx(row_idx),
    .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic e, input logic we, input logic [2:0] a,
                      input logic [7:0] d, input logic sr);
    bit wb, sw, show;
    rst = r; en = e; wr_en = we; wr_addr = a; wr_data = d; swap_req = sr;
    @(posedge clk);
    e_ack = 0; e_fs = 0; sw = 0; wb = !front;
    if (r) begin
      pos = 0; run = 0; fresh = 1; pend = 0; front = 0;
      for (int b = 0; b < 2; b++) for (int k = 0; k < 8; k++) mb[b][k] = 8'h00;
    end else begin
      if (!e) begin run = 0; pos = (pos / R) * R; end
      else if (!run) begin run = 1; pos = (pos / R) * R; e_fs = fresh; fresh = 0; end
      else if (pos == F - 1) begin sw = pend || sr; pos = 0; e_fs = 1; end
      else pos++;
      if (we) mb[wb][a] = d;
      pend = (pend || sr) && !sw;
      if (sw) front = !front;
      e_ack = sw;
    end
    e_idx = 3'(pos / R);
    show = run && (pos % R) >= B;
    e_row = show ? 8'h80 >> e_idx : 8'h00;
    e_col = show ? ~mb[front][e_idx] : 8'hFF;
    #1;
  endtask
  task automatic run_to(input int t);
    for (int i = 0; i < 4 * F && !(run && pos == t); i++) step(0, 1, 0, 0, 0, 0);
  endtask
  task automatic test_reset;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    checks++;
    if ({row, col, row_idx, swap_ack, frame_start} !== {8'h00, 8'hFF, 3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_state row=%h col=%h idx=%0d ack=%b fs=%b want 00 ff 0 0 0", row, col, row_idx, swap_ack, frame_start);
    end
    for (int i = 0; i < R; i++) begin
      step(0, 1, 0, 0, 0, 0);
      checks++;
      if ({row, col, row_idx, frame_start} !== {(i < B) ? 8'h00 : 8'h80, 8'hFF, 3'd0, i == 0}) begin
        errors++; $display("FAIL reset_first_row cyc=%0d row=%h col=%h idx=%0d fs=%b", i, row, col, row_idx, frame_start);
      end
    end
    step(0, 1, 0, 0, 0, 0);
    checks++;
    if (row_idx !== 3'd1) begin errors++; $display("FAIL reset_next_row idx=%0d want 1", row_idx); end
  endtask
  task automatic test_load_swap;
    int n;
    step(0, 1, 1, 3'd0, 8'h81, 0);
    step(0, 1, 1, 3'd3, 8'h3C, 0);
    step(0, 1, 0, 0, 0, 1);
    n = 0;
    while (!swap_ack && n < 2 * F) begin
      step(0, 1, 0, 0, 0, 0); n++;
      checks++;
      if ({swap_ack, frame_start} !== {e_ack, e_fs}) begin
        errors++; $display("FAIL load_swap_pulses ack=%b fs=%b want %b %b", swap_ack, frame_start, e_ack, e_fs);
      end
    end
    checks++;
    if (!swap_ack || frame_start !== 1'b1) begin errors++; $display("FAIL load_swap_ack ack=%b fs=%b want 1 1", swap_ack, frame_start); end
    run_to(B);
    checks++;
    if ({row, col} !== {8'h80, 8'h7E}) begin errors++; $display("FAIL load_row0 row=%h col=%h want 80 7e", row, col); end
    run_to(3 * R + B);
    checks++;
    if ({row, col} !== {8'h10, 8'hC3}) begin errors++; $display("FAIL load_row3 row=%h col=%h want 10 c3", row, col); end
  endtask
  task automatic test_boundary;
    int n, acks;
    run_to(F - 1);
    step(0, 1, 0, 0, 0, 1);
    checks++;
    if ({swap_ack, frame_start} !== 2'b11) begin errors++; $display("FAIL bnd_last_cycle ack=%b fs=%b want 1 1", swap_ack, frame_start); end
    step(0, 1, 0, 0, 0, 1);
    n = 1;
    while (!swap_ack && n < 2 * F) begin step(0, 1, 0, 0, 0, 0); n++; end
    checks++;
    if (!swap_ack || n != F) begin errors++; $display("FAIL bnd_first_cycle latency=%0d ack=%b want 64", n, swap_ack); end
    run_to(10);
    step(0, 1, 0, 0, 0, 1);
    run_to(30);
    step(0, 1, 0, 0, 0, 1);
    acks = 0;
    for (int i = 0; i < 60; i++) begin step(0, 1, 0, 0, 0, 0); acks += int'(swap_ack); end
    checks++;
    if (acks != 1) begin errors++; $display("FAIL bnd_double_req acks=%0d want 1", acks); end
  endtask
  task automatic test_enable_gap;
    int fsn;
    run_to(2 * R + B + 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0, 0);
      checks++;
      if ({row, col, row_idx, frame_start, swap_ack} !== {8'h00, 8'hFF, 3'd2, 1'b0, 1'b0}) begin
        errors++; $display("FAIL gap_off cyc=%0d row=%h col=%h idx=%0d fs=%b ack=%b", i, row, col, row_idx, frame_start, swap_ack);
      end
    end
    for (int i = 0; i < R; i++) begin
      step(0, 1, 0, 0, 0, 0);
      checks++;
      if ({row, col, row_idx} !== {(i < B) ? 8'h00 : 8'h20, (i < B) ? 8'hFF : e_col, 3'd2}) begin
        errors++; $display("FAIL gap_resume cyc=%0d row=%h col=%h idx=%0d want col %h", i, row, col, row_idx, e_col);
      end
    end
    fsn = 0;
    for (int i = 0; i < F; i++) begin step(0, 1, 0, 0, 0, 0); fsn += int'(frame_start); end
    checks++;
    if (fsn != 1) begin errors++; $display("FAIL gap_frame_start count=%0d want 1", fsn); end
  endtask
  task automatic test_reset_mid;
    int acks, lit;
    step(0, 1, 0, 0, 0, 1);
    run_to(5 * R + B + 1);
    step(1, 1, 0, 0, 0, 0);
    checks++;
    if ({row, col, row_idx, swap_ack, frame_start} !== {8'h00, 8'hFF, 3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL midrst_state row=%h col=%h idx=%0d ack=%b fs=%b", row, col, row_idx, swap_ack, frame_start);
    end
    step(0, 1, 0, 0, 0, 0);
    checks++;
    if ({row_idx, frame_start} !== {3'd0, 1'b1}) begin errors++; $display("FAIL midrst_restart idx=%0d fs=%b want 0 1", row_idx, frame_start); end
    acks = 0; lit = 0;
    for (int i = 0; i < 2 * F; i++) begin
      step(0, 1, 0, 0, 0, 0);
      acks += int'(swap_ack);
      lit += int'(col != 8'hFF);
    end
    checks++;
    if (acks != 0 || lit != 0) begin errors++; $display("FAIL midrst_clean acks=%0d lit=%0d want 0 0", acks, lit); end
  endtask
  task automatic test_write_swap;
    step(0, 1, 0, 0, 0, 1);
    run_to(F - 1);
    step(0, 1, 1, 3'd7, 8'hF0, 0);
    checks++;
    if (swap_ack !== 1'b1) begin errors++; $display("FAIL wswap_ack ack=%b want 1", swap_ack); end
    run_to(7 * R + B);
    checks++;
    if ({row, col} !== {8'h01, 8'h0F}) begin errors++; $display("FAIL wswap_row7 row=%h col=%h want 01 0f", row, col); end
  endtask
  task automatic test_random;
    logic e_r;
    e_r = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) e_r = !e_r;
      step($urandom_range(0, 399) == 0, e_r, 1'($urandom), 3'($urandom), 8'($urandom), $urandom_range(0, 29) == 0);
      checks++;
      if ({row, col, row_idx, swap_ack, frame_start} !== {e_row, e_col, e_idx, e_ack, e_fs}) begin
        errors++;
        $display("FAIL random cyc=%0d row=%h col=%h idx=%0d ack=%b fs=%b want %h %h %0d %b %b",
                 i, row, col, row_idx, swap_ack, frame_start, e_row, e_col, e_idx, e_ack, e_fs);
      end
    end
  endtask
  initial begin
    test_reset;
    test_load_swap;
    test_boundary;
    test_enable_gap;
    test_reset_mid;
    test_write_swap;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
